fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 113 +++++++++++
 tb/tb_fetch_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues single outstanding reads on the
// instruction bus and buffers returned words with their fetch addresses
// in a circular buffer for the decoder. Redirects flush the buffer and
// retarget fetch. A read still in flight when a redirect arrives is
// drained in DISCARD and its data is dropped.
module fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [ADDR_W-1:0]          add_bus,
  output logic                       rd_req,
  input  logic [ADDR_W-1:0]          data_bus,
  input  logic                       isCplt,
  input  logic                       isStop,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_addr,
  output logic [ADDR_W-1:0]          order,
  output logic [ADDR_W-1:0]          order_addr,
  output logic                       order_valid,
  input  logic                       order_take,
  output logic                       suspend,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t                    state;
  state_t                    state_next;
  logic [ADDR_W-1:0]         pc;
  logic [ADDR_W-1:0]         hold_addr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [PTR_W-1:0]          wr_ptr;
  logic [CNT_W-1:0]          count_next;
  logic                      push;
  logic                      pop;
  logic                      room;
  logic [ADDR_W-1:0]         mem_instr [DEPTH];
  logic [ADDR_W-1:0]         mem_addr  [DEPTH];

  // Push/pop qualification, next occupancy and next FSM state
  always_comb begin
    push       = (state == REQ) && isCplt && !redirect;
    pop        = order_valid && order_take && !redirect;
    count_next = redirect ? '0 : (count + CNT_W'(push) - CNT_W'(pop));
    room       = (count_next < DEPTH_C);
    state_next = state;
    case (state)
      IDLE: begin
        if (!isStop && room) state_next = REQ;
      end
      REQ: begin
        if (redirect && !isCplt)      state_next = DISCARD;
        else if (isCplt)              state_next = (!isStop && room) ? REQ : IDLE;
      end
      DISCARD: begin
        if (isCplt) state_next = isStop ? IDLE : REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control state: FSM, fetch PC, pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (redirect) begin
        pc     <= redirect_addr;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          pc     <= pc + ADDR_W'(4);
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Queue storage and the in-flight address kept for a discarded read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= data_bus;
      mem_addr[wr_ptr]  <= add_bus;
    end
    if (state == REQ) hold_addr <= pc;
  end

  // Bus and decoder-facing outputs straight from state and queue head
  always_comb begin
    rd_req      = (state != IDLE);
    add_bus     = (state == DISCARD) ? hold_addr : pc;
    order_valid = (count != '0);
    suspend     = !order_valid;
    order       = order_valid ? mem_instr[rd_ptr] : '0;
    order_addr  = order_valid ? mem_addr[rd_ptr]  : '0;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: expected queue entries go into a
// scoreboard as completions are driven; a monitor checks each entry the
// decoder consumes. Status outputs are checked with hand-computed values.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] add_bus;
  logic        rd_req;
  logic [31:0] data_bus = '0;
  logic        isCplt = 1'b0;
  logic        isStop = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic [31:0] order;
  logic [31:0] order_addr;
  logic        order_valid;
  logic        order_take = 1'b0;
  logic        suspend;
  logic [2:0]  count;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
  } entry_t;

  entry_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  fetch_queue #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .add_bus(add_bus), .rd_req(rd_req),
    .data_bus(data_bus), .isCplt(isCplt), .isStop(isStop),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .order(order), .order_addr(order_addr), .order_valid(order_valid),
    .order_take(order_take), .suspend(suspend), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_entry(input logic [31:0] a);
    entry_t e;
    e.instr = dat(a);
    e.addr  = a;
    sb.push_back(e);
  endtask

  // One clock of stimulus; inputs cleared again just after the edge
  task automatic tick(input logic take, input logic cplt, input logic [31:0] d,
                      input logic redir, input logic [31:0] raddr);
    order_take    = take;
    isCplt        = cplt;
    data_bus      = d;
    redirect      = redir;
    redirect_addr = raddr;
    if (redir) sb.delete();
    @(posedge clk);
    #1;
    order_take = 1'b0;
    isCplt     = 1'b0;
    redirect   = 1'b0;
    data_bus   = '0;
  endtask

  task automatic cplt_at(input logic [31:0] a, input logic take);
    chk("req_addr", add_bus, a);
    expect_entry(a);
    tick(take, 1'b1, dat(a), 1'b0, '0);
  endtask

  // Monitor: every consumed head must match the oldest expected entry
  always @(negedge clk) begin
    if (order_valid && order_take) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL head_unexpected: got addr 0x%08h expected no entry", order_addr);
      end else begin
        entry_t e;
        e = sb.pop_front();
        chk("head_instr", order, e.instr);
        chk("head_addr", order_addr, e.addr);
      end
    end
  end

  initial begin
    // Reset state
    @(posedge clk); #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_rd_req", 32'(rd_req), 0);
    chk("rst_suspend", 32'(suspend), 1);
    chk("rst_valid", 32'(order_valid), 0);
    chk("rst_add_bus", add_bus, 32'h0);
    chk("rst_order", order, 32'h0);
    chk("rst_order_addr", order_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Fill the queue from reset
    tick(0, 0, '0, 0, '0);
    chk("start_rd_req", 32'(rd_req), 1);
    cplt_at(32'h0, 0);
    cplt_at(32'h4, 0);
    cplt_at(32'h8, 0);
    cplt_at(32'hC, 0);
    chk("full_count", 32'(count), 4);
    chk("full_rd_req", 32'(rd_req), 0);
    chk("full_head_addr", order_addr, 32'h0);
    chk("full_suspend", 32'(suspend), 0);

    // Single pop from full restarts fetch at 0x10
    tick(1, 0, '0, 0, '0);
    chk("pop_count", 32'(count), 3);
    chk("pop_rd_req", 32'(rd_req), 1);
    cplt_at(32'h10, 0);
    chk("refill_count", 32'(count), 4);
    chk("refill_rd_req", 32'(rd_req), 0);

    // Simultaneous push and pop at count 2
    tick(1, 0, '0, 0, '0);
    tick(1, 0, '0, 0, '0);
    chk("c2_count", 32'(count), 2);
    chk("c2_head", order_addr, 32'hC);
    cplt_at(32'h14, 1);
    chk("pp_count", 32'(count), 2);
    chk("pp_head", order_addr, 32'h10);
    chk("pp_add_bus", add_bus, 32'h18);

    // Redirect to 0x8 while a read at 0x18 is in flight
    tick(0, 0, '0, 1, 32'h8);
    chk("rd1_count", 32'(count), 0);
    chk("rd1_valid", 32'(order_valid), 0);
    chk("rd1_add_bus", add_bus, 32'h18);
    chk("rd1_rd_req", 32'(rd_req), 1);
    tick(0, 1, 32'hDEAD_0018, 0, '0);
    chk("rd1_drop_count", 32'(count), 0);
    chk("rd1_new_addr", add_bus, 32'h8);

    // Redirect to 0x100 while the read at 0x8 is outstanding
    tick(0, 0, '0, 1, 32'h100);
    chk("rd2_hold", add_bus, 32'h8);
    tick(0, 0, '0, 0, '0);
    chk("rd2_hold2", add_bus, 32'h8);
    chk("rd2_rd_req", 32'(rd_req), 1);
    tick(0, 1, 32'hDEAD_0008, 0, '0);
    chk("rd2_drop_count", 32'(count), 0);
    cplt_at(32'h100, 0);
    chk("rd2_count", 32'(count), 1);
    chk("rd2_head_addr", order_addr, 32'h100);
    chk("rd2_head_instr", order, dat(32'h100));

    // Redirect coincident with completion, then PC wrap
    tick(0, 1, 32'hDEAD_0104, 1, 32'hFFFF_FFF8);
    chk("rc_count", 32'(count), 0);
    chk("rc_rd_req", 32'(rd_req), 1);
    cplt_at(32'hFFFF_FFF8, 0);
    cplt_at(32'hFFFF_FFFC, 0);
    chk("wrap_add_bus", add_bus, 32'h0);
    chk("wrap_count", 32'(count), 2);
    tick(1, 0, '0, 0, '0);
    tick(1, 0, '0, 0, '0);
    chk("empty_count", 32'(count), 0);
    chk("empty_suspend", 32'(suspend), 1);
    chk("empty_order", order, 32'h0);
    chk("empty_order_addr", order_addr, 32'h0);

    // isStop lets the outstanding read finish, then holds off new ones
    isStop = 1'b1;
    cplt_at(32'h0, 0);
    chk("stop_count", 32'(count), 1);
    chk("stop_rd_req", 32'(rd_req), 0);
    tick(0, 0, '0, 0, '0);
    chk("stop_hold", 32'(rd_req), 0);
    isStop = 1'b0;
    tick(0, 0, '0, 0, '0);
    cplt_at(32'h4, 0);
    cplt_at(32'h8, 0);
    chk("pre_rst_count", 32'(count), 3);

    // Asynchronous reset mid-request
    rst = 1'b0;
    #1;
    sb.delete();
    chk("arst_count", 32'(count), 0);
    chk("arst_rd_req", 32'(rd_req), 0);
    chk("arst_add_bus", add_bus, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick(0, 0, '0, 0, '0);
    chk("restart_rd_req", 32'(rd_req), 1);
    cplt_at(32'h0, 0);
    tick(1, 0, '0, 0, '0);
    chk("final_count", 32'(count), 0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
